lnzd_scan_ctrl: RTL and testbench
=================================

Name: lnzd_scan_ctrl

Overview:
- Sequential companion to the range-limited leading-nonzero detector.
- Accepts one BIT_WIDTH-bit occupancy vector and an index range [start, stop).
- Serialises every set bit inside that range as a stream of positions, lowest index first, one per cycle under valid/ready backpressure.
- Feeds downstream hash-bucket/sparse-index consumers, so they never process zero entries.

Parameters:
- BIT_WIDTH, 8, vector width; power of 2, >= 2.
- POS_W, clog2(BIT_WIDTH), derived localparam; position width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream vector valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  BIT_WIDTH  occupancy vector.
- in_start  input  POS_W+1  first index of range, inclusive.
- in_stop  input  POS_W+1  end of range, exclusive; the value BIT_WIDTH is legal.
- out_valid  output  1  position beat valid.
- out_ready  input  1  downstream accepts beat.
- out_pos  output  POS_W  index of current set bit.
- out_last  output  1  current beat is final beat for this vector.
- out_empty  output  1  range held no set bit; beat carries no position.
- busy  output  1  vector loaded, not yet fully drained.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values and gating:
  - At reset: state=IDLE, remaining vector=0, out_valid=0, out_last=0, out_empty=0, out_pos=0, busy=0.
  - While rst is high, in_ready=0 and out_valid=0.
- States: IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, register the masked vector: bit i = in_data[i] if in_start <= i < effective stop, else 0. Then go to SCAN.
  - Effective stop = min(in_stop, BIT_WIDTH).
  - If in_start >= effective stop, the masked vector is all zero.
- SCAN:
  - in_ready=0; no overlap between vectors.
  - out_valid=1 from the first cycle after acceptance; latency is 1 cycle.
  - out_pos = lowest set index of the remaining vector. It comes from a combinational priority encoder on the registered vector.
  - out_last=1 when exactly one bit remains.
  - If the remaining vector is zero on entry: a single beat with out_empty=1, out_last=1, out_pos=0.
  - On out_valid && out_ready: clear bit out_pos. If out_last, go to IDLE.
  - With out_ready held high, throughput is one beat per cycle.
- busy=1 exactly while in SCAN.
- Backpressure: while out_valid && !out_ready, out_pos, out_last and out_empty are held stable; no state change.
- Back-to-back vectors: the next vector is accepted in the IDLE cycle following the last beat. This costs one bubble; it is required, not optional.
- Reset mid-scan: remaining beats are discarded with no further out_valid. in_ready=1 on the first cycle after rst deasserts.
- in_data, in_start and in_stop are sampled only at acceptance. Later input changes have no effect.

Test Plan:
- BIT_WIDTH=8, out_ready=1. Accept in_data=8'b1010_0110, start=0, stop=8 → out_pos 1,2,5,7 on 4 consecutive cycles starting 1 cycle after accept; out_last only on 7; in_ready=1 the next cycle.
- Same data, start=2, stop=6 → beats 2,5; out_last on 5; bits 1 and 7 never emitted.
- Empty ranges → exactly one beat each with out_empty=1, out_last=1, out_pos=0, then IDLE:
  - in_data=8'hFF, start=4, stop=4.
  - in_data=8'h00, start=0, stop=8.
- Backpressure: in_data=8'h81, full range, out_ready=0 for 3 cycles → out_pos=0 held stable 3 cycles. Then with out_ready=1 → beats 0, then 7 with last.
- Reset mid-scan: in_data=8'hFF, full range; assert rst for 1 cycle after 2 beats → out_valid=0 from the next cycle, no beats 2..7, in_ready=1 after release. A new vector 8'h10 then gives a single beat pos 4, last=1.
- Top-bit boundary:
  - in_data=8'h80, start=7, stop=8 → pos 7, last.
  - Repeat with stop=9 (clamped) → identical response.
  - start=9 → empty beat.

Source files
------------

// File: rtl/lnzd_scan_ctrl.sv
// lnzd_scan_ctrl
// Serialises the set bits of one occupancy vector, restricted to an index
// window [start, stop), as a stream of positions (lowest index first) under
// valid/ready handshakes. One vector is in flight at a time. The beat fields
// come from a priority encoder on the registered remaining vector, so they
// are stable for as long as the current beat is stalled.

module lnzd_scan_ctrl #(
  parameter  int BIT_WIDTH = 8,
  localparam int POS_W     = $clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic [POS_W:0]       in_start,
  input  logic [POS_W:0]       in_stop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POS_W-1:0]     out_pos,
  output logic                 out_last,
  output logic                 out_empty,
  output logic                 busy
);

  localparam logic [0:0]           IDLE    = 1'b0;
  localparam logic [0:0]           SCAN    = 1'b1;
  localparam logic [POS_W:0]       WIDTH_L = (POS_W + 1)'(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] VEC_ONE = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0] VEC_ZERO = BIT_WIDTH'(0);

  logic [0:0]           state_r;
  logic [BIT_WIDTH-1:0] vec_r;

  logic [POS_W:0]       eff_stop_s;
  logic [BIT_WIDTH-1:0] masked_s;
  logic [POS_W-1:0]     pos_s;
  logic                 in_scan_s;
  logic                 vec_zero_s;
  logic                 one_left_s;
  logic                 last_s;
  logic                 in_ready_s;
  logic                 out_valid_s;

  // Clamp the window end to the vector width and mask the incoming vector.
  always_comb begin
    eff_stop_s = in_stop;
    masked_s   = VEC_ZERO;
    if (in_stop > WIDTH_L) begin
      eff_stop_s = WIDTH_L;
    end else begin
      eff_stop_s = in_stop;
    end
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if ((in_start <= (POS_W + 1)'(i)) && ((POS_W + 1)'(i) < eff_stop_s)) begin
        masked_s[i] = in_data[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end
  end

  // Priority encoder: lowest set index of the remaining vector (0 when empty).
  always_comb begin
    pos_s = POS_W'(0);
    for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
      if (vec_r[i]) begin
        pos_s = POS_W'(i);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  // Beat qualifiers and handshake gating; both handshakes are blocked during reset.
  always_comb begin
    in_scan_s   = (state_r == SCAN);
    vec_zero_s  = (vec_r == VEC_ZERO);
    one_left_s  = !vec_zero_s && ((vec_r & (vec_r - VEC_ONE)) == VEC_ZERO);
    last_s      = in_scan_s && (vec_zero_s || one_left_s);
    in_ready_s  = (state_r == IDLE) && !rst;
    out_valid_s = in_scan_s && !rst;
  end

  // Accept a vector in IDLE; in SCAN retire the lowest set bit on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= VEC_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_s) begin
            vec_r   <= masked_s;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          if (out_valid_s && out_ready) begin
            vec_r <= vec_r & (vec_r - VEC_ONE);
            if (last_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          vec_r   <= VEC_ZERO;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_pos   = pos_s;
  assign out_last  = last_s;
  assign out_empty = in_scan_s && vec_zero_s;
  assign busy      = in_scan_s;

endmodule

// File: tb/tb_lnzd_scan_ctrl.sv
// Directed bench for lnzd_scan_ctrl with a beat scoreboard.
module tb_lnzd_scan_ctrl;

  typedef struct packed {
    logic [2:0] pos;
    logic       last;
    logic       empty;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_start;
  logic [3:0] in_stop;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_pos;
  logic       out_last;
  logic       out_empty;
  logic       busy;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];

  lnzd_scan_ctrl #(.BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_start(in_start), .in_stop(in_stop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_last(out_last), .out_empty(out_empty),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: positions in [start, min(stop,8)) with data bit set, lowest first.
  task automatic push_expected(input logic [7:0] d, input int start, input int stop);
    int    eff;
    int    n;
    beat_t b;
    eff = (stop > 8) ? 8 : stop;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= start && i < eff && d[i]) begin
        b.pos = 3'(i); b.last = 1'b0; b.empty = 1'b0;
        sb.push_back(b);
        n++;
      end
    end
    if (n == 0) begin
      b.pos = 3'd0; b.last = 1'b1; b.empty = 1'b1;
      sb.push_back(b);
    end else begin
      sb[sb.size() - 1].last = 1'b1;
    end
  endtask

  // Present a vector for one cycle; inputs are scrambled right after acceptance.
  task automatic send(input logic [7:0] d, input logic [3:0] s, input logic [3:0] e, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_start = s; in_stop = e;
    @(negedge clk);
    chk({tag, ":in_ready_at_accept"}, {7'd0, in_ready}, 8'd1);
    push_expected(d, int'(s), int'(e));
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_start = 4'd0; in_stop = 4'd8;
  endtask

  // Pop and compare beats; with out_ready high, one beat per cycle is required.
  task automatic drain(input string tag);
    int    cycles;
    int    nexp;
    beat_t got;
    beat_t exp;
    cycles = 0;
    nexp = sb.size();
    while (sb.size() != 0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      chk({tag, ":busy"}, {7'd0, busy}, 8'd1);
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        got = '{pos: out_pos, last: out_last, empty: out_empty};
        chk({tag, ":beat"}, {3'd0, got}, {3'd0, exp});
      end
    end
    chk({tag, ":cycles"}, 8'(cycles), 8'(nexp));
    sb.delete();
    @(negedge clk);
    chk({tag, ":idle_valid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, ":idle_ready"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_start = 4'd0; in_stop = 4'd8;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst:out_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst:busy", {7'd0, busy}, 8'd0);
    chk("rst:flags", {3'd0, out_pos, out_last, out_empty}, 8'd0);
    chk("rst:in_ready_after", {7'd0, in_ready}, 8'd1);

    send(8'b1010_0110, 4'd0, 4'd8, "full");
    drain("full");
    send(8'b1010_0110, 4'd2, 4'd6, "window");
    drain("window");
    send(8'hFF, 4'd4, 4'd4, "empty_ff");
    drain("empty_ff");
    send(8'h00, 4'd0, 4'd8, "empty_00");
    drain("empty_00");

    // Backpressure: the first beat must hold steady while stalled.
    out_ready = 1'b0;
    send(8'h81, 4'd0, 4'd8, "bp");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp:valid", {7'd0, out_valid}, 8'd1);
      chk("bp:hold", {3'd0, out_pos, out_last, out_empty}, 8'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp");

    // Reset after two beats: the remaining six are dropped.
    send(8'hFF, 4'd0, 4'd8, "rstmid");
    for (int k = 0; k < 2; k++) begin
      beat_t exp;
      @(negedge clk);
      exp = sb.pop_front();
      chk("rstmid:valid", {7'd0, out_valid}, 8'd1);
      chk("rstmid:beat", {3'd0, out_pos, out_last, out_empty}, {3'd0, exp});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid:valid_in_rst", {7'd0, out_valid}, 8'd0);
    chk("rstmid:ready_in_rst", {7'd0, in_ready}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rstmid:valid_after", {7'd0, out_valid}, 8'd0);
    chk("rstmid:ready_after", {7'd0, in_ready}, 8'd1);
    chk("rstmid:busy_after", {7'd0, busy}, 8'd0);
    send(8'h10, 4'd0, 4'd8, "post_rst");
    drain("post_rst");

    send(8'h80, 4'd7, 4'd8, "top");
    drain("top");
    send(8'h80, 4'd7, 4'd9, "top_clamp");
    drain("top_clamp");
    send(8'h80, 4'd9, 4'd8, "start9");
    drain("start9");
    send(8'hFF, 4'd5, 4'd15, "clamp_ff");
    drain("clamp_ff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
